// File: rtl/softreg_seq_pkg.sv
// Shared types and default sizes for the SoftReg command sequencer.
package softreg_seq_pkg;

  localparam int unsigned NUM_CMDS_DEF       = 16;
  localparam int unsigned DLY_W_DEF          = 16;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 4096;

  typedef enum logic [2:0] {
    IDLE,
    DELAY,
    ISSUE,
    WAIT_RESP,
    DONE
  } seq_state_e;

  typedef struct packed {
    logic                 is_write;
    logic [31:0]          addr;
    logic [63:0]          data;
    logic [DLY_W_DEF-1:0] delay;
  } cmd_t;

endpackage

// File: rtl/softreg_cmd_table.sv
// Command storage: NUM_CMDS entries, one synchronous write port, one asynchronous read port.
module softreg_cmd_table
  import softreg_seq_pkg::*;
#(
  parameter  int unsigned NUM_CMDS = NUM_CMDS_DEF,
  localparam int unsigned IDX_W    = $clog2(NUM_CMDS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  cmd_t             wr_cmd,
  input  logic [IDX_W-1:0] rd_idx,
  output cmd_t             rd_cmd
);

  cmd_t mem [NUM_CMDS];

  always_ff @(posedge clk) begin
    if (we) mem[wr_idx] <= wr_cmd;
  end

  assign rd_cmd = mem[rd_idx];

endmodule

// File: rtl/softreg_cmd_sequencer.sv
// Programmable SoftReg request sequencer: issues table entries in order, stalls on reads.
// Optional read-response timeout enabled by defining SEQ_TIMEOUT_EN.
module softreg_cmd_sequencer
  import softreg_seq_pkg::*;
#(
  parameter  int unsigned NUM_CMDS       = NUM_CMDS_DEF,
  parameter  int unsigned DLY_W          = DLY_W_DEF,
  parameter  int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  localparam int unsigned IDX_W          = $clog2(NUM_CMDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [IDX_W-1:0] load_idx,
  input  logic             load_is_write,
  input  logic [31:0]      load_addr,
  input  logic [63:0]      load_data,
  input  logic [DLY_W-1:0] load_delay,
  input  logic             start,
  input  logic [IDX_W:0]   cfg_len,
  output logic             softreg_req_valid,
  output logic             softreg_req_isWrite,
  output logic [31:0]      softreg_req_addr,
  output logic [63:0]      softreg_req_data,
  input  logic             softreg_resp_valid,
  input  logic [63:0]      softreg_resp_data,
  output logic             rd_valid,
  output logic [63:0]      rd_data,
  output logic             busy,
  output logic             done,
  output logic             timeout_err
);

  localparam logic [IDX_W:0] LEN_MAX = (IDX_W + 1)'(NUM_CMDS);

  seq_state_e       state, state_next;
  logic [IDX_W-1:0] cmd_idx;
  logic [IDX_W:0]   len;
  logic [DLY_W-1:0] dly_cnt;
  logic [IDX_W-1:0] rd_idx;
  logic             table_we;
  logic             start_ok;
  logic             last;
  logic             tmo_hit;
  cmd_t             wr_cmd;
  cmd_t             cur_cmd;

  assign wr_cmd = '{is_write: load_is_write, addr: load_addr, data: load_data,
                    delay: DLY_W_DEF'(load_delay)};

  softreg_cmd_table #(.NUM_CMDS(NUM_CMDS)) u_table (
    .clk    (clk),
    .we     (table_we),
    .wr_idx (load_idx),
    .wr_cmd (wr_cmd),
    .rd_idx (rd_idx),
    .rd_cmd (cur_cmd)
  );

`ifdef SEQ_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TMO_W-1:0] tmo_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   tmo_cnt <= '0;
    else if (state == ISSUE)    tmo_cnt <= '0;
    else if (state == WAIT_RESP) tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign tmo_hit = (state == WAIT_RESP) && !softreg_resp_valid &&
                   (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // The single read port serves both the entry being issued and the delay of the one that follows.
  always_comb begin
    start_ok = start && (state == IDLE || state == DONE);
    table_we = load_valid && (state == IDLE || state == DONE);
    last     = ({1'b0, cmd_idx} + 1'b1) == len;
    rd_idx   = '0;
    unique case (state)
      DELAY:            rd_idx = cmd_idx;
      ISSUE, WAIT_RESP: rd_idx = cmd_idx + 1'b1;
      default:          rd_idx = '0;
    endcase
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE, DONE: state_next = (start_ok && cfg_len != '0) ? DELAY : IDLE;
      DELAY:      if (dly_cnt == '0) state_next = ISSUE;
      ISSUE: begin
        if (!softreg_req_isWrite) state_next = WAIT_RESP;
        else                      state_next = last ? DONE : DELAY;
      end
      WAIT_RESP: begin
        if (softreg_resp_valid) state_next = last ? DONE : DELAY;
        else if (tmo_hit)       state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_idx             <= '0;
      len                 <= '0;
      dly_cnt             <= '0;
      softreg_req_valid   <= 1'b0;
      softreg_req_isWrite <= 1'b0;
      softreg_req_addr    <= '0;
      softreg_req_data    <= '0;
      rd_valid            <= 1'b0;
      rd_data             <= '0;
      busy                <= 1'b0;
      done                <= 1'b0;
      timeout_err         <= 1'b0;
    end else begin
      softreg_req_valid   <= 1'b0;
      softreg_req_isWrite <= 1'b0;
      softreg_req_addr    <= '0;
      softreg_req_data    <= '0;
      rd_valid            <= 1'b0;

      if (start_ok) begin
        cmd_idx     <= '0;
        len         <= (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
        done        <= (cfg_len == '0);
        busy        <= (cfg_len != '0);
        timeout_err <= 1'b0;
      end

      if (state != DELAY && state_next == DELAY)
        dly_cnt <= DLY_W'(cur_cmd.delay);
      else if (state == DELAY && dly_cnt != '0)
        dly_cnt <= dly_cnt - 1'b1;

      if (state == DELAY && dly_cnt == '0) begin
        softreg_req_valid   <= 1'b1;
        softreg_req_isWrite <= cur_cmd.is_write;
        softreg_req_addr    <= cur_cmd.addr;
        softreg_req_data    <= cur_cmd.data;
      end

      if ((state == ISSUE || state == WAIT_RESP) && state_next == DELAY)
        cmd_idx <= cmd_idx + 1'b1;

      if (state == WAIT_RESP && softreg_resp_valid) begin
        rd_valid <= 1'b1;
        rd_data  <= softreg_resp_data;
      end

      if (tmo_hit) timeout_err <= 1'b1;

      if (state != DONE && state_next == DONE) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

endmodule
